// File: rtl/ex_mem_pkg.sv
// Shared constants and types for the EX->MEM pipeline register.
// Holds the pipeline-wide defines plus the decoded pipeline-control action.
package ex_mem_pkg;

    // Pipeline-wide control encodings
    localparam logic RstEnable    = 1'b1;
    localparam logic Stop         = 1'b1;
    localparam logic NoStop       = 1'b0;
    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    // Datapath widths
    localparam int RegBus       = 32;
    localparam int RegAddrBus   = 5;
    localparam int DoubleRegBus = 64;
    localparam int StallBus     = 6;

    // Zero values used for reset, flush and bubbles
    localparam logic [RegBus-1:0]       ZeroWord   = '0;
    localparam logic [RegAddrBus-1:0]   NOPRegAddr = '0;
    localparam logic [DoubleRegBus-1:0] ZeroDouble = '0;

    // Positions of the stages this register cares about in the stall vector
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;

    // What the register does on the next edge, once reset is excluded
    typedef enum logic [1:0] {
        ACT_PASS   = 2'd0,
        ACT_HOLD   = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_FLUSH  = 2'd3
    } pipe_action_e;

    // Everything the memory stage consumes from this register
    typedef struct packed {
        logic [RegAddrBus-1:0] wd;
        logic                  wreg;
        logic [RegBus-1:0]     wdata;
        logic                  whilo;
        logic [RegBus-1:0]     hi;
        logic [RegBus-1:0]     lo;
    } mem_bundle_t;

    // A bundle that writes nothing anywhere downstream
    function automatic mem_bundle_t nopBundle();
        mem_bundle_t b;
        b.wd    = NOPRegAddr;
        b.wreg  = WriteDisable;
        b.wdata = ZeroWord;
        b.whilo = WriteDisable;
        b.hi    = ZeroWord;
        b.lo    = ZeroWord;
        return b;
    endfunction

    // Flush beats everything; EX stopped alone makes a bubble; EX running
    // always passes (EX running with MEM stopped is not produced by the
    // stall controller and is simply treated as a pass); both stopped holds.
    function automatic pipe_action_e decodeAction(input logic flush,
                                                  input logic [StallBus-1:0] stall);
        pipe_action_e act;
        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall[STALL_EX] == NoStop) begin
            act = ACT_PASS;
        end else if (stall[STALL_MEM] == NoStop) begin
            act = ACT_BUBBLE;
        end else begin
            act = ACT_HOLD;
        end
        return act;
    endfunction

endpackage

// File: rtl/ex_mem.sv
// EX->MEM pipeline register: passes, holds, bubbles or flushes the execute
// result, and loops the madd/msub partial product and cycle index back to EX.
module ex_mem
    import ex_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [5:0]  stall,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic        ex_whilo,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic        mem_whilo,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    pipe_action_e action;
    mem_bundle_t  exBundle;
    mem_bundle_t  memBundle_q, memBundle_d;
    logic [63:0]  hilo_q, hilo_d;
    logic [1:0]   cnt_q, cnt_d;

    assign action = decodeAction(flush, stall);

    assign exBundle.wd    = ex_wd;
    assign exBundle.wreg  = ex_wreg;
    assign exBundle.wdata = ex_wdata;
    assign exBundle.whilo = ex_whilo;
    assign exBundle.hi    = ex_hi;
    assign exBundle.lo    = ex_lo;

    // Next-state selection; accumulate state survives only while EX is stopped
    always_comb begin
        memBundle_d = memBundle_q;
        hilo_d      = hilo_q;
        cnt_d       = cnt_q;
        case (action)
            ACT_FLUSH: begin
                memBundle_d = nopBundle();
                hilo_d      = ZeroDouble;
                cnt_d       = 2'b00;
            end
            ACT_BUBBLE: begin
                memBundle_d = nopBundle();
                hilo_d      = hilo_i;
                cnt_d       = cnt_i;
            end
            ACT_PASS: begin
                memBundle_d = exBundle;
                hilo_d      = ZeroDouble;
                cnt_d       = 2'b00;
            end
            ACT_HOLD: begin
                memBundle_d = memBundle_q;
                hilo_d      = hilo_i;
                cnt_d       = cnt_i;
            end
            default: begin
                memBundle_d = nopBundle();
                hilo_d      = ZeroDouble;
                cnt_d       = 2'b00;
            end
        endcase
    end

    // State register with synchronous reset to the no-op values
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            memBundle_q <= nopBundle();
            hilo_q      <= ZeroDouble;
            cnt_q       <= 2'b00;
        end else begin
            memBundle_q <= memBundle_d;
            hilo_q      <= hilo_d;
            cnt_q       <= cnt_d;
        end
    end

    assign mem_wd    = memBundle_q.wd;
    assign mem_wreg  = memBundle_q.wreg;
    assign mem_wdata = memBundle_q.wdata;
    assign mem_whilo = memBundle_q.whilo;
    assign mem_hi    = memBundle_q.hi;
    assign mem_lo    = memBundle_q.lo;
    assign hilo_o    = hilo_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_ex_mem.sv
// Directed self-checking bench for the EX->MEM pipeline register.
module tb_ex_mem;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic        ex_whilo;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic        mem_whilo;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;

    ex_mem dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .ex_wd     (ex_wd),
        .ex_wreg   (ex_wreg),
        .ex_wdata  (ex_wdata),
        .ex_whilo  (ex_whilo),
        .ex_hi     (ex_hi),
        .ex_lo     (ex_lo),
        .hilo_i    (hilo_i),
        .cnt_i     (cnt_i),
        .mem_wd    (mem_wd),
        .mem_wreg  (mem_wreg),
        .mem_wdata (mem_wdata),
        .mem_whilo (mem_whilo),
        .mem_hi    (mem_hi),
        .mem_lo    (mem_lo),
        .hilo_o    (hilo_o),
        .cnt_o     (cnt_o)
    );

    // Free-running clock, 10 time units per period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stall controller must never stop MEM while EX runs
    always @(negedge clk) begin
        if (!rst) begin
            assert (!(stall[3] == 1'b0 && stall[4] == 1'b1))
                else $error("[TB] illegal stall vector %b", stall);
        end
    end

    // Advance one edge, then settle so outputs are sampled away from the edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    // One counted comparison
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        total++;
        assert (observed === expected)
            else begin
                bad++;
                $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
            end
    endtask

    initial begin
        // Reset with live-looking EX data
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        ex_wd = 5'd7; ex_wreg = 1'b1; ex_wdata = 32'hDEADBEEF;
        ex_whilo = 1'b1; ex_hi = 32'h11; ex_lo = 32'h22;
        hilo_i = 64'h1234; cnt_i = 2'd1;
        applyStimulus();
        checkOutput("rst_wd",    64'(mem_wd),    64'd0);
        checkOutput("rst_wreg",  64'(mem_wreg),  64'd0);
        checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("rst_whilo", 64'(mem_whilo), 64'd0);
        checkOutput("rst_hilo",  hilo_o,         64'd0);
        checkOutput("rst_cnt",   64'(cnt_o),     64'd0);
        applyStimulus();
        checkOutput("rst2_wdata", 64'(mem_wdata), 64'd0);
        rst = 1'b0;

        // Pass: everything copied, accumulate state cleared
        stall = 6'b0; ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h12345678;
        ex_whilo = 1'b1; ex_hi = 32'h1; ex_lo = 32'h2;
        hilo_i = 64'hFFFF; cnt_i = 2'd2;
        applyStimulus();
        checkOutput("pass_wd",    64'(mem_wd),    64'd3);
        checkOutput("pass_wreg",  64'(mem_wreg),  64'd1);
        checkOutput("pass_wdata", 64'(mem_wdata), 64'h12345678);
        checkOutput("pass_whilo", 64'(mem_whilo), 64'd1);
        checkOutput("pass_hi",    64'(mem_hi),    64'h1);
        checkOutput("pass_lo",    64'(mem_lo),    64'h2);
        checkOutput("pass_hilo",  hilo_o,         64'd0);
        checkOutput("pass_cnt",   64'(cnt_o),     64'd0);

        // Bubble: EX stopped alone
        stall = 6'b001111; ex_wreg = 1'b1; ex_whilo = 1'b1;
        hilo_i = 64'hA5A5_0000_0000_5A5A; cnt_i = 2'd1;
        applyStimulus();
        checkOutput("bub_wreg",  64'(mem_wreg),  64'd0);
        checkOutput("bub_wd",    64'(mem_wd),    64'd0);
        checkOutput("bub_whilo", 64'(mem_whilo), 64'd0);
        checkOutput("bub_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("bub_hilo",  hilo_o,         64'hA5A5_0000_0000_5A5A);
        checkOutput("bub_cnt",   64'(cnt_o),     64'd1);

        // Hold: load a value, then stop EX and MEM for three cycles
        stall = 6'b0; ex_wd = 5'd9; ex_wreg = 1'b1; ex_wdata = 32'hCAFEF00D;
        ex_whilo = 1'b0; hilo_i = 64'h0; cnt_i = 2'd0;
        applyStimulus();
        checkOutput("load_wdata", 64'(mem_wdata), 64'hCAFEF00D);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            ex_wd = 5'(i + 1); ex_wreg = 1'b0; ex_wdata = 32'h11111111 * (i + 1);
            hilo_i = 64'h70 + 64'(i); cnt_i = 2'd3;
            applyStimulus();
            checkOutput("hold_wdata", 64'(mem_wdata), 64'hCAFEF00D);
            checkOutput("hold_wd",    64'(mem_wd),    64'd9);
            checkOutput("hold_wreg",  64'(mem_wreg),  64'd1);
            checkOutput("hold_hilo",  hilo_o,         64'h70 + 64'(i));
            checkOutput("hold_cnt",   64'(cnt_o),     64'd3);
        end
        stall = 6'b0; ex_wd = 5'd12; ex_wreg = 1'b1; ex_wdata = 32'h0BADF00D;
        applyStimulus();
        checkOutput("rel_wdata", 64'(mem_wdata), 64'h0BADF00D);
        checkOutput("rel_wd",    64'(mem_wd),    64'd12);
        checkOutput("rel_hilo",  hilo_o,         64'd0);

        // Flush while EX is stopped alone
        flush = 1'b1; stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hBEEF;
        ex_wreg = 1'b1;
        applyStimulus();
        checkOutput("fl_bub_wreg", 64'(mem_wreg), 64'd0);
        checkOutput("fl_bub_hilo", hilo_o,        64'd0);
        checkOutput("fl_bub_cnt",  64'(cnt_o),    64'd0);
        checkOutput("fl_bub_wd",   64'(mem_wd),   64'd0);

        // Flush while both stopped, after loading a live value
        flush = 1'b0; stall = 6'b0; ex_wdata = 32'h55AA55AA; ex_whilo = 1'b1;
        applyStimulus();
        checkOutput("pre_fl_whilo", 64'(mem_whilo), 64'd1);
        flush = 1'b1; stall = 6'b011111; cnt_i = 2'd2; hilo_i = 64'h9;
        applyStimulus();
        checkOutput("fl_hold_wdata", 64'(mem_wdata), 64'd0);
        checkOutput("fl_hold_whilo", 64'(mem_whilo), 64'd0);
        checkOutput("fl_hold_cnt",   64'(cnt_o),     64'd0);

        // Flush beats a pass
        stall = 6'b0; ex_wdata = 32'h77777777;
        applyStimulus();
        checkOutput("fl_pass_wdata", 64'(mem_wdata), 64'd0);
        flush = 1'b0;

        // madd: first cycle EX stopped with partial product
        stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'h5;
        ex_wreg = 1'b0; ex_whilo = 1'b1; ex_hi = 32'h0; ex_lo = 32'h105;
        applyStimulus();
        checkOutput("madd1_hilo",  hilo_o,         64'h5);
        checkOutput("madd1_cnt",   64'(cnt_o),     64'd1);
        checkOutput("madd1_whilo", 64'(mem_whilo), 64'd0);
        // Second cycle: EX completes and releases the stall
        stall = 6'b0; cnt_i = 2'd2; hilo_i = 64'h5;
        applyStimulus();
        checkOutput("madd2_hilo",  hilo_o,         64'd0);
        checkOutput("madd2_cnt",   64'(cnt_o),     64'd0);
        checkOutput("madd2_hi",    64'(mem_hi),    64'h0);
        checkOutput("madd2_lo",    64'(mem_lo),    64'h105);
        checkOutput("madd2_whilo", 64'(mem_whilo), 64'd1);

        // Reset mid-madd together with flush
        stall = 6'b001111; cnt_i = 2'd1; hilo_i = 64'hC0FFEE;
        applyStimulus();
        checkOutput("rmadd_pre_cnt", 64'(cnt_o), 64'd1);
        rst = 1'b1; flush = 1'b1;
        applyStimulus();
        checkOutput("rmadd_hilo", hilo_o,     64'd0);
        checkOutput("rmadd_cnt",  64'(cnt_o), 64'd0);
        rst = 1'b0; flush = 1'b0; stall = 6'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
